// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the breakout game-flow controller: state codes and
// the widths of the state, lives, level and frame-count fields.
package game_sequencer_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned FRAME_W = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_ATTRACT     = 3'd0,
        ST_SERVE       = 3'd1,
        ST_PLAY        = 3'd2,
        ST_PAUSED      = 3'd3,
        ST_LOST        = 3'd4,
        ST_LEVEL_CLEAR = 3'd5,
        ST_GAME_OVER   = 3'd6
    } game_state_e;

    // States in which the game logic is asked for a per-frame update.
    function automatic logic is_update_state(input game_state_e s);
        return (s == ST_SERVE) || (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/game_sequencer_edge_detect.sv
// One-bit registered rising-edge detector for an already-synchronised button.
// The history flop resets to 1 so a button held through reset must be released
// and pressed again before it produces an edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // Next history value is simply the current button level.
    always_comb begin
        prev_d = din;
    end

    // History register; reset treats the button as already pressed.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Breakout game-flow controller: issues per-frame update requests, tracks
// lives and level, sequences serve/pause/loss/clear/game-over and keeps a
// free-running vblank counter.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned START_LIVES        = 3,
    parameter int unsigned LOST_DELAY_FRAMES  = 60,
    parameter int unsigned CLEAR_DELAY_FRAMES = 90,
    parameter int unsigned MAX_LEVEL          = 15
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               VBLANK_START,
    input  logic               BTN_START,
    input  logic               BTN_PAUSE,
    input  logic               UPDATE_DONE,
    input  logic               BALL_LOST,
    input  logic               BRICKS_CLEARED,
    output logic               START_UPDATE,
    output logic [STATE_W-1:0] GAME_STATE,
    output logic [LIVES_W-1:0] LIVES,
    output logic [LEVEL_W-1:0] LEVEL,
    output logic [FRAME_W-1:0] FRAME_COUNT,
    output logic               OVERRUN
);

    localparam int unsigned DELAY_MAX = (LOST_DELAY_FRAMES > CLEAR_DELAY_FRAMES)
                                        ? LOST_DELAY_FRAMES : CLEAR_DELAY_FRAMES;
    localparam int unsigned DELAY_W   = $clog2(DELAY_MAX + 1);

    // Counter value at which the final vblank of each hold period arrives.
    localparam logic [DELAY_W-1:0] LOST_LAST  = DELAY_W'(LOST_DELAY_FRAMES - 1);
    localparam logic [DELAY_W-1:0] CLEAR_LAST = DELAY_W'(CLEAR_DELAY_FRAMES - 1);

    game_state_e        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    logic               paused_from_play_q, paused_from_play_d;
    logic               start_update_q, start_update_d;
    logic               in_flight_q, in_flight_d;
    logic               overrun_q, overrun_d;

    logic start_rise;
    logic pause_rise;
    logic busy;

    edge_detect u_start_edge (
        .clk  (CLK),
        .rst  (RESET),
        .din  (BTN_START),
        .rise (start_rise)
    );

    edge_detect u_pause_edge (
        .clk  (CLK),
        .rst  (RESET),
        .din  (BTN_PAUSE),
        .rise (pause_rise)
    );

    // An UPDATE_DONE in the same cycle frees the slot for a new request.
    assign busy = in_flight_q & ~UPDATE_DONE;

    // Update handshake: request on vblank when idle, flag overruns, count frames.
    always_comb begin
        start_update_d = VBLANK_START & is_update_state(state_q) & ~busy;
        in_flight_d    = start_update_d | busy;
        overrun_d      = overrun_q | (VBLANK_START & busy);
        frame_count_d  = frame_count_q + FRAME_W'(VBLANK_START);
    end

    // Game-flow FSM with lives/level bookkeeping and the hold-delay counter.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d            = state_q;
        lives_d            = lives_q;
        level_d            = level_q;
        delay_d            = delay_q;
        paused_from_play_d = paused_from_play_q;

        case (state_q)
            ST_ATTRACT: begin
                if (start_rise) begin
                    lives_d = LIVES_W'(START_LIVES);
                    level_d = LEVEL_W'(1);
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (start_rise) begin
                    state_d = ST_PLAY;
                end else if (pause_rise) begin
                    paused_from_play_d = 1'b0;
                    state_d            = ST_PAUSED;
                end
            end
            ST_PLAY: begin
                if (BALL_LOST) begin
                    lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                    state_d = ST_LOST;
                end else if (BRICKS_CLEARED) begin
                    level_d = (level_q >= LEVEL_W'(MAX_LEVEL)) ? level_q
                                                               : level_q + LEVEL_W'(1);
                    state_d = ST_LEVEL_CLEAR;
                end else if (pause_rise) begin
                    paused_from_play_d = 1'b1;
                    state_d            = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_rise) begin
                    state_d = paused_from_play_q ? ST_PLAY : ST_SERVE;
                end
            end
            ST_LOST: begin
                if (VBLANK_START) begin
                    if (delay_q == LOST_LAST) begin
                        state_d = (lives_q == '0) ? ST_GAME_OVER : ST_SERVE;
                    end else begin
                        delay_d = delay_q + DELAY_W'(1);
                    end
                end
            end
            ST_LEVEL_CLEAR: begin
                if (VBLANK_START) begin
                    if (delay_q == CLEAR_LAST) begin
                        state_d = ST_SERVE;
                    end else begin
                        delay_d = delay_q + DELAY_W'(1);
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start_rise) begin
                    state_d = ST_ATTRACT;
                end
            end
            default: begin
                state_d = ST_ATTRACT;
            end
        endcase

        // Each hold period starts counting from zero on entry.
        if (state_d != state_q) begin
            delay_d = '0;
        end
    end

    // All controller state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q            <= ST_ATTRACT;
            lives_q            <= '0;
            level_q            <= '0;
            delay_q            <= '0;
            frame_count_q      <= '0;
            paused_from_play_q <= 1'b0;
            start_update_q     <= 1'b0;
            in_flight_q        <= 1'b0;
            overrun_q          <= 1'b0;
        end else begin
            state_q            <= state_d;
            lives_q            <= lives_d;
            level_q            <= level_d;
            delay_q            <= delay_d;
            frame_count_q      <= frame_count_d;
            paused_from_play_q <= paused_from_play_d;
            start_update_q     <= start_update_d;
            in_flight_q        <= in_flight_d;
            overrun_q          <= overrun_d;
        end
    end

    assign START_UPDATE = start_update_q;
    assign GAME_STATE   = state_q;
    assign LIVES        = lives_q;
    assign LEVEL        = level_q;
    assign FRAME_COUNT  = frame_count_q;
    assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed game-flow scenarios plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_game_sequencer;

    logic        clk;
    logic        reset;
    logic        vblank_start;
    logic        btn_start;
    logic        btn_pause;
    logic        update_done;
    logic        ball_lost;
    logic        bricks_cleared;
    logic        start_update;
    logic [2:0]  game_state;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic [15:0] frame_count;
    logic        overrun;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state, kept as plain integers.
    int m_state, m_lives, m_level, m_frame, m_wait;
    bit m_su, m_ovr, m_busy, m_from_play, m_sprev, m_pprev;

    // Game-logic emulation: answer each request after a short latency.
    bit auto_done  = 1'b0;
    int done_timer = 0;

    game_sequencer dut (
        .CLK            (clk),
        .RESET          (reset),
        .VBLANK_START   (vblank_start),
        .BTN_START      (btn_start),
        .BTN_PAUSE      (btn_pause),
        .UPDATE_DONE    (update_done),
        .BALL_LOST      (ball_lost),
        .BRICKS_CLEARED (bricks_cleared),
        .START_UPDATE   (start_update),
        .GAME_STATE     (game_state),
        .LIVES          (lives),
        .LEVEL          (level),
        .FRAME_COUNT    (frame_count),
        .OVERRUN        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Game rules applied to the inputs presented this cycle.
    task automatic model_step();
        bit se, pe, slot_taken;
        int nxt;
        if (reset) begin
            m_state = 0; m_lives = 0; m_level = 0; m_frame = 0; m_wait = 0;
            m_su = 0; m_ovr = 0; m_busy = 0; m_from_play = 0;
            m_sprev = 1; m_pprev = 1;
            return;
        end
        se = btn_start && !m_sprev;
        pe = btn_pause && !m_pprev;
        m_sprev = btn_start;
        m_pprev = btn_pause;

        slot_taken = m_busy && !update_done;
        m_su = vblank_start && (m_state == 1 || m_state == 2) && !slot_taken;
        if (vblank_start && slot_taken) m_ovr = 1;
        if (m_su) m_busy = 1;
        else if (update_done) m_busy = 0;
        m_frame = (m_frame + int'(vblank_start)) % 65536;

        nxt = m_state;
        case (m_state)
            0: if (se) begin m_lives = 3; m_level = 1; nxt = 1; end
            1: if (se) nxt = 2;
               else if (pe) begin m_from_play = 0; nxt = 3; end
            2: if (ball_lost) begin
                   m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                   nxt = 4;
               end else if (bricks_cleared) begin
                   m_level = (m_level < 15) ? m_level + 1 : 15;
                   nxt = 5;
               end else if (pe) begin
                   m_from_play = 1; nxt = 3;
               end
            3: if (pe) nxt = m_from_play ? 2 : 1;
            4: if (vblank_start) begin
                   m_wait++;
                   if (m_wait == 60) nxt = (m_lives == 0) ? 6 : 1;
               end
            5: if (vblank_start) begin
                   m_wait++;
                   if (m_wait == 90) nxt = 1;
               end
            6: if (se) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt != m_state) m_wait = 0;
        m_state = nxt;
    endtask

    // One clock: predict, clock, compare every output, then drop the pulses.
    task automatic step();
        if (reset) done_timer = 0;
        if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) update_done = 1'b1;
        end
        model_step();
        @(posedge clk);
        #1;
        check("state",        game_state,   m_state);
        check("lives",        lives,        m_lives);
        check("level",        level,        m_level);
        check("frame_count",  frame_count,  m_frame);
        check("start_update", start_update, m_su);
        check("overrun",      overrun,      m_ovr);
        vblank_start = 1'b0;
        update_done  = 1'b0;
        ball_lost    = 1'b0;
        if (auto_done && m_su) done_timer = $urandom_range(1, 5);
    endtask

    // n vblanks, spaced widely enough that emulated updates always complete.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vblank_start = 1'b1;
            step();
            repeat ($urandom_range(6, 10)) step();
        end
    endtask

    task automatic press_start();
        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
    endtask

    task automatic press_pause();
        btn_pause = 1'b0;
        step();
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
    endtask

    initial begin
        bit wrapped;
        reset = 1'b1; vblank_start = 1'b0; btn_start = 1'b1; btn_pause = 1'b0;
        update_done = 1'b0; ball_lost = 1'b0; bricks_cleared = 1'b0;

        // Reset values, with start held through reset.
        step();
        check("rst_state", game_state, 0);
        check("rst_lives", lives, 0);
        check("rst_level", level, 0);
        check("rst_su",    start_update, 0);
        reset = 1'b0;
        repeat (3) step();
        check("held_btn_no_edge", game_state, 0);

        // Start and serve.
        press_start();
        check("serve_state", game_state, 1);
        check("serve_lives", lives, 3);
        check("serve_level", level, 1);
        vblank_start = 1'b1;
        step();
        check("serve_req", start_update, 1);
        step();
        check("serve_req_one_cycle", start_update, 0);
        update_done = 1'b1;
        step();

        // Overrun in PLAY.
        press_start();
        check("play_state", game_state, 2);
        vblank_start = 1'b1;
        step();
        check("ovr_first_req", start_update, 1);
        repeat (3) step();
        vblank_start = 1'b1;
        step();
        check("ovr_no_second_req", start_update, 0);
        check("ovr_set", overrun, 1);
        step();
        vblank_start = 1'b1;
        update_done  = 1'b1;
        step();
        check("done_with_vblank_req", start_update, 1);
        update_done = 1'b1;
        step();
        auto_done = 1'b1;

        // Lose all lives.
        for (int i = 0; i < 3; i++) begin
            ball_lost = 1'b1;
            step();
            check("lost_state", game_state, 4);
            check("lost_lives", lives, 2 - i);
            frames(59);
            check("lost_hold", game_state, 4);
            frames(1);
            check("lost_exit", game_state, (i < 2) ? 1 : 6);
            if (i < 2) press_start();
        end
        press_start();
        check("over_to_attract", game_state, 0);
        press_start();
        press_start();
        check("replay_play", game_state, 2);

        // Simultaneous loss and clear: loss wins.
        ball_lost = 1'b1;
        bricks_cleared = 1'b1;
        step();
        bricks_cleared = 1'b0;
        check("both_state", game_state, 4);
        check("both_level", level, 1);
        frames(60);
        press_start();

        // Level clear.
        bricks_cleared = 1'b1;
        step();
        bricks_cleared = 1'b0;
        check("clear_state", game_state, 5);
        check("clear_level", level, 2);
        frames(89);
        check("clear_hold", game_state, 5);
        frames(1);
        check("clear_exit", game_state, 1);
        press_start();

        // Level saturation.
        for (int i = 0; i < 14; i++) begin
            bricks_cleared = 1'b1;
            step();
            bricks_cleared = 1'b0;
            for (int f = 0; f < 90; f++) begin
                vblank_start = 1'b1;
                step();
            end
            press_start();
        end
        check("level_saturated", level, 15);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            reset          = ($urandom_range(0, 999) == 0);
            vblank_start   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 23) == 0) btn_pause = ~btn_pause;
            ball_lost      = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 99) == 0) bricks_cleared = ~bricks_cleared;
            if ($urandom_range(0, 29) == 0) update_done = 1'b1;
            step();
        end
        reset = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; bricks_cleared = 1'b0;
        step();
        reset = 1'b0;

        // Pause through a frame-counter wrap, then resume.
        press_start();
        press_start();
        check("pre_pause_play", game_state, 2);
        press_pause();
        check("paused_state", game_state, 3);
        wrapped = 1'b0;
        for (int g = 0; g < 70000; g++) begin
            vblank_start = 1'b1;
            step();
            if (m_frame == 0) begin
                wrapped = 1'b1;
                break;
            end
        end
        check("wrap_reached", wrapped, 1);
        check("wrap_count", frame_count, 0);
        press_pause();
        check("resume_play", game_state, 2);

        // Reset with an update in flight.
        auto_done = 1'b0;
        done_timer = 0;
        update_done = 1'b1;
        step();
        vblank_start = 1'b1;
        step();
        check("inflight_req", start_update, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_state", game_state, 0);
        check("midrst_lives", lives, 0);
        check("midrst_level", level, 0);
        check("midrst_frame", frame_count, 0);
        check("midrst_su",    start_update, 0);
        check("midrst_ovr",   overrun, 0);
        update_done = 1'b1;
        step();
        check("stale_done_ignored", overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
